lsu_rmw_ctrl: RTL and testbench
===============================

Name: lsu_rmw_ctrl

Overview:
Load/store sequencer between the core's LSU request interface and the word-only data memory. The memory has 1-cycle synchronous read latency and no byte enables. This block performs byte and halfword loads with sign/zero extension, and implements sub-word stores as read-modify-write. It stalls the core for every access that needs more than one cycle, and flags misaligned or illegal-size accesses.

Parameters:
MISALIGN_CHECK, 1, 1: misaligned access raises fault_o and skips memory. 0: low address bits are ignored and the access is forced aligned.

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-high
core_req_i  input  1  core requests a memory access this cycle
core_we_i  input  1  1 = store, 0 = load
core_size_i  input  3  RISC-V funct3: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU
core_addr_i  input  32  byte address
core_wd_i  input  32  store data, right-aligned
core_rd_o  output  32  extended load data, valid when load completes
core_stall_o  output  1  1 = core must hold request and all inputs stable
fault_o  output  1  1-cycle pulse for a misaligned or illegal-size request
mem_req_o  output  1  memory request
mem_we_o  output  1  memory write enable
mem_addr_o  output  32  word address, always {core_addr_i[31:2], 2'b00}
mem_wd_o  output  32  memory write data
mem_rd_i  input  32  memory read data; valid the cycle after a read issue while req=1, we=0 and the address is unchanged

Behaviour:
- States: IDLE, LD_WAIT, LD_DONE, RMW_RD, RMW_WR. Registers: state, word_q[31:0]. Reset: IDLE, word_q = 0.
- Outputs are combinational from state and core inputs. In IDLE with core_req_i = 0: mem_req_o = 0, mem_we_o = 0, core_stall_o = 0, fault_o = 0, core_rd_o = 0.
- Fault check (IDLE only), when MISALIGN_CHECK = 1:
  - H/HU with addr[0] = 1 is a fault.
  - W with addr[1:0] != 0 is a fault.
- Illegal size (3, 6, 7) is always a fault.
- On fault: fault_o = 1, mem_req_o = 0, core_stall_o = 0, stay in IDLE. The request completes in 1 cycle with no memory access.
- Word store (IDLE): mem_req_o = 1, mem_we_o = 1, mem_wd_o = core_wd_i, stall = 0. Completes in 1 cycle, no state change.
- Load (IDLE): mem_req_o = 1, we = 0, stall = 1, go to LD_WAIT.
- LD_WAIT: hold req = 1, we = 0, same address; word_q <= mem_rd_i; stall = 1; go to LD_DONE.
- LD_DONE: mem_req_o = 0, stall = 0, core_rd_o = extract(word_q); go to IDLE. A load takes 3 cycles, 2 of them stalled.
- Extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Sub-word store (IDLE): issue read (req = 1, we = 0), stall = 1, go to RMW_RD.
- RMW_RD: hold the read; word_q <= mem_rd_i with the target byte or halfword lane replaced by core_wd_i[7:0] or [15:0]; stall = 1; go to RMW_WR.
- RMW_WR: mem_req_o = 1, we = 1, mem_wd_o = word_q, stall = 0; go to IDLE. Total 3 cycles; other bytes of the word are preserved.
- Back-to-back: the cycle after a completing cycle is IDLE and accepts the next request with no bubble.
- Memory read data arriving as 0xDEADBEEF (out of range) is passed through or merged unchanged; it is not a fault.
- core_req_i deasserting mid-sequence is a protocol violation; behaviour is unspecified but the FSM still returns to IDLE within 2 cycles.
- Reset asserted in any state:
  - Immediate IDLE; mem_req_o = 0 and mem_we_o = 0 in the same cycle (asynchronous).
  - A pending RMW write is dropped and memory is unmodified.

Test Plan:
- Word 0x10 = 0x8899AABB. lb @0x13 -> stall high 2 cycles, core_rd_o = 0xFFFFFF88 in cycle 3. lbu @0x13 -> 0x00000088. lh @0x10 -> 0xFFFFAABB. lhu @0x12 -> 0x00008899.
- sh 0x00001234 @0x12 on word 0x8899AABB -> read, then write 0x1234AABB at 0x10 in cycle 3. sb 0x55 @0x11 -> 0x889955BB.
- sw 0xCAFEF00D @0x20 -> mem_we_o = 1 in cycle 1, stall never asserted; a following lw @0x20 returns 0xCAFEF00D.
- lw @0x11, lh @0x13 and size 3 -> fault_o pulse, mem_req_o stays 0, memory unchanged. With MISALIGN_CHECK = 0, lw @0x11 reads word 0x10.
- rst_i asserted during RMW_RD of sb @0x10 -> mem_req_o = 0 immediately, state IDLE, word 0x10 unchanged.
- Stream lw, sb, sw, lbu with core_req_i always high -> cycle counts 3, 3, 1, 3 and correct data, no lost or duplicated accesses.

Source files
------------

// File: rtl/lsu_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_rmw_ctrl
//   Load/store sequencer between the core LSU and a word-only data memory.
//   The memory has 1-cycle synchronous read latency and no byte enables, so:
//     - byte/halfword loads read the word and extract + extend the lane,
//     - sub-word stores are done as read-modify-write,
//     - word stores go straight through in one cycle.
//   Misaligned (when MISALIGN_CHECK != 0) and illegal-size requests pulse
//   fault_o for one cycle and never touch memory.
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   core_req_i         core access request
//   core_we_i          1 = store, 0 = load
//   core_size_i        funct3 size code (0 B, 1 H, 2 W, 4 BU, 5 HU)
//   core_addr_i        byte address
//   core_wd_i          right-aligned store data
//   core_rd_o          extended load data, valid in the load's completing cycle
//   core_stall_o       core must hold its request stable
//   fault_o            1-cycle pulse on misaligned / illegal-size request
//   mem_req_o/_we_o    memory request / write enable
//   mem_addr_o         word address
//   mem_wd_o           memory write data
//   mem_rd_i           memory read data (one cycle after a read issue)
// -----------------------------------------------------------------------------
module lsu_rmw_ctrl #(
   parameter int MISALIGN_CHECK = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        fault_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LD_WAIT = 3'd1,
      S_LD_DONE = 3'd2,
      S_RMW_RD  = 3'd3,
      S_RMW_WR  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] word_q, word_d;

   logic illegal_size;
   logic misaligned;
   logic req_fault;

   // Sizes 3, 6 and 7 have no meaning for loads or stores.
   assign illegal_size = (core_size_i == 3'd3) || (core_size_i == 3'd6) ||
                         (core_size_i == 3'd7);

   assign misaligned = (MISALIGN_CHECK != 0) &&
                       (((core_size_i[1:0] == 2'b01) && core_addr_i[0]) ||
                        ((core_size_i == 3'd2) && (core_addr_i[1:0] != 2'b00)));

   assign req_fault  = illegal_size || misaligned;

   // Low address bits are never presented to memory; with the check off this
   // is what forces a misaligned access onto its containing word.
   assign mem_addr_o = {core_addr_i[31:2], 2'b00};

   // Pick the addressed lane out of a word and extend it.
   function automatic logic [31:0] extract(input logic [31:0] w,
                                           input logic [2:0]  size,
                                           input logic [1:0]  a);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (a)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (size[1:0])
         2'b00:   r = size[2] ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   r = size[2] ? {16'h0, h} : {{16{h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Replace the addressed lane of a word with the low store bits.
   function automatic logic [31:0] merge(input logic [31:0] w,
                                         input logic [2:0]  size,
                                         input logic [1:0]  a,
                                         input logic [31:0] wd);
      logic [31:0] r;
      r = w;
      if (size[1:0] == 2'b00) begin
         case (a)
            2'd0:    r[7:0]   = wd[7:0];
            2'd1:    r[15:8]  = wd[7:0];
            2'd2:    r[23:16] = wd[7:0];
            default: r[31:24] = wd[7:0];
         endcase
      end else if (a[1]) begin
         r[31:16] = wd[15:0];
      end else begin
         r[15:0]  = wd[15:0];
      end
      return r;
   endfunction

   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      core_rd_o    = 32'h0;
      core_stall_o = 1'b0;
      fault_o      = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_wd_o     = 32'h0;

      case (state_q)
         S_IDLE: begin
            if (core_req_i) begin
               if (req_fault) begin
                  fault_o = 1'b1;
               end else if (core_we_i && (core_size_i == 3'd2)) begin
                  mem_req_o = 1'b1;
                  mem_we_o  = 1'b1;
                  mem_wd_o  = core_wd_i;
               end else begin
                  // Loads and sub-word stores both start with a read.
                  mem_req_o    = 1'b1;
                  core_stall_o = 1'b1;
                  state_d      = core_we_i ? S_RMW_RD : S_LD_WAIT;
               end
            end
         end
         S_LD_WAIT: begin
            mem_req_o    = 1'b1;
            core_stall_o = 1'b1;
            word_d       = mem_rd_i;
            state_d      = S_LD_DONE;
         end
         S_LD_DONE: begin
            core_rd_o = extract(word_q, core_size_i, core_addr_i[1:0]);
            state_d   = S_IDLE;
         end
         S_RMW_RD: begin
            mem_req_o    = 1'b1;
            core_stall_o = 1'b1;
            word_d       = merge(mem_rd_i, core_size_i, core_addr_i[1:0], core_wd_i);
            state_d      = S_RMW_WR;
         end
         S_RMW_WR: begin
            mem_req_o = 1'b1;
            mem_we_o  = 1'b1;
            mem_wd_o  = word_q;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Reset kills any memory strobe in the same cycle, so a pending RMW
      // write can never land while reset is asserted.
      if (rst_i) begin
         mem_req_o    = 1'b0;
         mem_we_o     = 1'b0;
         core_stall_o = 1'b0;
         fault_o      = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         word_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
      end
   end

endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_rmw_ctrl
//   Transaction-level reference model (a shadow word memory plus lane
//   arithmetic) predicts per-cycle outputs of lsu_rmw_ctrl; a bus-side
//   synchronous memory model serves the DUT. Directed cases pin the model with
//   hand-computed literals, then randomized traffic runs against the model.
// -----------------------------------------------------------------------------
module tb_lsu_rmw_ctrl;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        core_req_i, core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i, core_wd_i;
   logic [31:0] core_rd_o, mem_addr_o, mem_wd_o, mem_rd_i;
   logic        core_stall_o, fault_o, mem_req_o, mem_we_o;

   // second instance with the alignment check disabled
   logic [31:0] nc_rd_o, nc_addr_o, nc_wd_o, nc_rd_i;
   logic        nc_stall_o, nc_fault_o, nc_req_o, nc_we_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lsu_rmw_ctrl #(.MISALIGN_CHECK(1)) u_dut (
      .clk_i(clk), .rst_i(rst_i), .core_req_i(core_req_i), .core_we_i(core_we_i),
      .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
      .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .fault_o(fault_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i));

   lsu_rmw_ctrl #(.MISALIGN_CHECK(0)) u_nc (
      .clk_i(clk), .rst_i(rst_i), .core_req_i(core_req_i), .core_we_i(core_we_i),
      .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
      .core_rd_o(nc_rd_o), .core_stall_o(nc_stall_o), .fault_o(nc_fault_o),
      .mem_req_o(nc_req_o), .mem_we_o(nc_we_o), .mem_addr_o(nc_addr_o),
      .mem_wd_o(nc_wd_o), .mem_rd_i(nc_rd_i));

   // The second instance only ever reads word 0x10.
   assign nc_rd_i = (nc_addr_o == 32'h10) ? 32'h8899AABB : 32'h0;

   // ---------------- bus-side memory: 64 words at 0x00..0xFF -----------------
   logic [31:0] init_mem [64];
   logic [31:0] dut_mem  [64];
   logic [31:0] ref_mem  [64];
   logic        mem_init;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) dut_mem[i] <= init_mem[i];
      end else if (mem_req_o && mem_we_o && (mem_addr_o < 32'h100)) begin
         dut_mem[mem_addr_o[7:2]] <= mem_wd_o;
      end
      if (mem_req_o && !mem_we_o)
         mem_rd_i <= (mem_addr_o < 32'h100) ? dut_mem[mem_addr_o[7:2]] : 32'hDEADBEEF;
   end

   // ---------------- reference model ----------------------------------------
   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return (a < 32'h100) ? ref_mem[a[7:2]] : 32'hDEADBEEF;
   endfunction

   function automatic bit ref_fault(input logic [2:0] size, input logic [31:0] a);
      if (size == 3 || size == 6 || size == 7) return 1'b1;
      if ((size == 1 || size == 5) && (a % 2 != 0)) return 1'b1;
      if (size == 2 && (a % 4 != 0)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] size,
                                            input logic [31:0] a);
      logic [31:0] v;
      int sh;
      if (size == 0 || size == 4) begin
         sh = int'(a % 4) * 8;
         v  = (w >> sh) & 32'hFF;
         if (size == 0 && v >= 32'h80) v = v + 32'hFFFFFF00;
      end else if (size == 1 || size == 5) begin
         sh = int'((a / 2) % 2) * 16;
         v  = (w >> sh) & 32'hFFFF;
         if (size == 1 && v >= 32'h8000) v = v + 32'hFFFF0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] size,
                                             input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] mask;
      int sh;
      if (size == 2) return wd;
      if (size == 0 || size == 4) begin
         sh = int'(a % 4) * 8;  mask = 32'hFF;
      end else begin
         sh = int'((a / 2) % 2) * 16;  mask = 32'hFFFF;
      end
      return (w & ~(mask << sh)) | ((wd & mask) << sh);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Drive one request (called just after a rising edge) and check every cycle
   // of it. ncyc is measured from the DUT's stall output.
   task automatic run_txn(input bit we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, output int ncyc, output logic [31:0] rd_got);
      bit flt, ld, wst, rmw;
      int n;
      logic [31:0] old_w, exp_rd, new_w;
      flt    = ref_fault(size, addr);
      ld     = !flt && !we;
      wst    = !flt && we && size == 2;
      rmw    = !flt && we && size != 2;
      n      = (flt || wst) ? 1 : 3;
      old_w  = ref_read(addr);
      exp_rd = ref_load(old_w, size, addr);
      new_w  = ref_store(old_w, size, addr, wd);
      if ((wst || rmw) && addr < 32'h100) ref_mem[addr[7:2]] = new_w;

      core_req_i = 1'b1;  core_we_i = we;  core_size_i = size;
      core_addr_i = addr; core_wd_i = wd;
      ncyc = 99;  rd_got = 32'h0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check("fault", fault_o, flt && k == 0);
         check("stall", core_stall_o, k < n - 1);
         check("addr", mem_addr_o, addr & 32'hFFFFFFFC);
         check("req", mem_req_o, wst || rmw || (ld && k < 2));
         check("we", mem_we_o, wst || (rmw && k == 2));
         if (wst || (rmw && k == 2)) check("wdata", mem_wd_o, new_w);
         if (ld && k == 2) begin
            rd_got = core_rd_o;
            check("rdata", core_rd_o, exp_rd);
         end
         if (!core_stall_o && ncyc == 99) ncyc = k + 1;
         @(posedge clk); #1;
      end
   endtask

   task automatic idle_cycle();
      core_req_i = 1'b0;
      @(negedge clk);
      check("idle_req", mem_req_o, 1'b0);
      check("idle_we", mem_we_o, 1'b0);
      check("idle_stall", core_stall_o, 1'b0);
      check("idle_fault", fault_o, 1'b0);
      check("idle_rd", core_rd_o, 32'h0);
      @(posedge clk); #1;
   endtask

   int          nc;
   logic [31:0] rd;

   initial begin
      for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
      init_mem[4] = 32'h8899AABB;
      init_mem[8] = 32'h0;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_mem[i];

      rst_i = 1'b1;  mem_init = 1'b1;
      core_req_i = 1'b1;  core_we_i = 1'b1;  core_size_i = 3'd2;
      core_addr_i = 32'h10;  core_wd_i = 32'h0;
      #1;
      check("rst_req", mem_req_o, 1'b0);
      check("rst_we", mem_we_o, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b0;  mem_init = 1'b0;
      idle_cycle();

      // sub-word loads of word 0x10 = 0x8899AABB
      run_txn(0, 3'd0, 32'h13, 0, nc, rd);  check("lb_13", rd, 32'hFFFFFF88);
      check("lb_cycles", nc, 3);
      run_txn(0, 3'd4, 32'h13, 0, nc, rd);  check("lbu_13", rd, 32'h00000088);
      run_txn(0, 3'd1, 32'h10, 0, nc, rd);  check("lh_10", rd, 32'hFFFFAABB);
      run_txn(0, 3'd5, 32'h12, 0, nc, rd);  check("lhu_12", rd, 32'h00008899);

      // read-modify-write stores
      run_txn(1, 3'd0, 32'h11, 32'h55, nc, rd);
      check("sb_cycles", nc, 3);
      idle_cycle();
      check("sb_mem", dut_mem[4], 32'h889955BB);
      run_txn(1, 3'd1, 32'h12, 32'h1234, nc, rd);
      idle_cycle();
      check("sh_mem", dut_mem[4], 32'h123455BB);

      // word store then load back
      run_txn(1, 3'd2, 32'h20, 32'hCAFEF00D, nc, rd);  check("sw_cycles", nc, 1);
      run_txn(0, 3'd2, 32'h20, 0, nc, rd);             check("lw_20", rd, 32'hCAFEF00D);

      // faults
      run_txn(0, 3'd2, 32'h11, 0, nc, rd);  check("flt_lw_cycles", nc, 1);
      run_txn(1, 3'd1, 32'h13, 32'hFFFF, nc, rd);
      run_txn(1, 3'd3, 32'h10, 32'hFFFF, nc, rd);
      idle_cycle();
      check("flt_mem", dut_mem[4], 32'h123455BB);

      // alignment check disabled: lw @0x11 reads word 0x10
      core_req_i = 1'b1;  core_we_i = 1'b0;  core_size_i = 3'd2;  core_addr_i = 32'h11;
      @(negedge clk);
      check("nc_fault", nc_fault_o, 1'b0);
      check("nc_req", nc_req_o, 1'b1);
      check("nc_addr", nc_addr_o, 32'h10);
      check("nc_stall0", nc_stall_o, 1'b1);
      @(posedge clk); #1; @(negedge clk);
      check("nc_stall1", nc_stall_o, 1'b1);
      @(posedge clk); #1; @(negedge clk);
      check("nc_stall2", nc_stall_o, 1'b0);
      check("nc_rd", nc_rd_o, 32'h8899AABB);
      @(posedge clk); #1;
      idle_cycle();

      // reset during RMW_RD of sb @0x10: write must be dropped
      core_req_i = 1'b1;  core_we_i = 1'b1;  core_size_i = 3'd0;
      core_addr_i = 32'h10;  core_wd_i = 32'h77;
      @(negedge clk);
      check("rmwrst_stall", core_stall_o, 1'b1);
      @(posedge clk); #2;
      rst_i = 1'b1;
      #1;
      check("rmwrst_req", mem_req_o, 1'b0);
      check("rmwrst_we", mem_we_o, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      idle_cycle();
      check("rmwrst_mem", dut_mem[4], 32'h123455BB);

      // back-to-back stream, request held high
      run_txn(0, 3'd2, 32'h20, 0, nc, rd);         check("st_lw_cyc", nc, 3);
      check("st_lw", rd, 32'hCAFEF00D);
      run_txn(1, 3'd0, 32'h21, 32'hAB, nc, rd);     check("st_sb_cyc", nc, 3);
      run_txn(1, 3'd2, 32'h24, 32'h11223344, nc, rd); check("st_sw_cyc", nc, 1);
      run_txn(0, 3'd4, 32'h21, 0, nc, rd);         check("st_lbu_cyc", nc, 3);
      check("st_lbu", rd, 32'h000000AB);

      // randomized traffic, including out-of-range words (0xDEADBEEF)
      for (int t = 0; t < 400; t++) begin
         logic [2:0]  sz;
         logic [31:0] a;
         case ($urandom_range(0, 9))
            0, 1:    sz = 3'd0;
            2:       sz = 3'd4;
            3, 4:    sz = 3'd1;
            5:       sz = 3'd5;
            6, 7:    sz = 3'd2;
            8:       sz = 3'd3;
            default: sz = ($urandom_range(0, 1) == 1) ? 3'd6 : 3'd7;
         endcase
         a = ($urandom_range(0, 9) == 0) ? 32'h100 + $urandom_range(0, 255)
                                         : 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 3'd2) a = a & 32'hFFFFFFFC;
            if (sz == 3'd1 || sz == 3'd5) a = a & 32'hFFFFFFFE;
         end
         run_txn($urandom_range(0, 1) == 1, sz, a, $urandom, nc, rd);
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end
      idle_cycle();

      for (int i = 0; i < 64; i++) check($sformatf("mem[%0d]", i), dut_mem[i], ref_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
